// File: rtl/rf_dump_streamer_if.sv
// Byte-stream channel carrying the framed register dump toward a UART TX or trace FIFO.
// The master drives the data; the slave drives out_ready.
interface rf_dump_streamer_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport master (
        output out_valid,
        output out_byte,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_byte,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rf_dump_streamer.sv
// Scans sccomp's register file on a start pulse and streams a framed byte dump:
// header, PC (big-endian), then NREGS register words (big-endian, r0 forced to zero).
module rf_dump_streamer #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned NREGS  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [31:0]           pc_in,
    output logic [4:0]            reg_sel,
    input  logic [31:0]           reg_data,
    rf_dump_streamer_if.master    strm,
    output logic                  busy,
    output logic                  done
);

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC_B,
        S_SEL,
        S_REG_B,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [4:0]  idx_q,   idx_d;
    logic [4:0]  sel_q,   sel_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] word_q,  word_d;
    logic [31:0] tx_word;
    logic [7:0]  tx_byte;

    assign reg_sel = sel_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            pc_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
        end
    end

    // Stream outputs are decoded from the async-reset state, so reset drops out_valid at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        pc_d    = pc_q;
        word_d  = word_q;

        strm.out_valid = 1'b0;
        strm.out_byte  = '0;
        strm.out_last  = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;

        tx_word = (state_q == S_PC_B) ? pc_q : word_q;
        unique case (cnt_q)
            2'd0:    tx_byte = tx_word[31:24];
            2'd1:    tx_byte = tx_word[23:16];
            2'd2:    tx_byte = tx_word[15:8];
            default: tx_byte = tx_word[7:0];
        endcase

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pc_d    = pc_in;
                    cnt_d   = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                strm.out_valid = 1'b1;
                strm.out_byte  = HEADER;
                if (strm.out_ready) begin
                    cnt_d   = '0;
                    state_d = S_PC_B;
                end
            end
            S_PC_B: begin
                strm.out_valid = 1'b1;
                strm.out_byte  = tx_byte;
                if (strm.out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        idx_d   = '0;
                        sel_d   = '0;
                        state_d = S_SEL;
                    end
                end
            end
            S_SEL: begin
                word_d  = (idx_q == '0) ? '0 : reg_data;
                state_d = S_REG_B;
            end
            S_REG_B: begin
                strm.out_valid = 1'b1;
                strm.out_byte  = tx_byte;
                strm.out_last  = (idx_q == LAST_IDX) && (cnt_q == 2'd3);
                if (strm.out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (idx_q < LAST_IDX) begin
                            idx_d   = idx_q + 5'd1;
                            sel_d   = idx_q + 5'd1;
                            state_d = S_SEL;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Self-checking bench for rf_dump_streamer: randomized data and backpressure checked
// against a byte-level frame model built directly from the dump format.
module tb_rf_dump_streamer;

    localparam int FRAME = 133;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] pc_in;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        busy;
    logic        done;

    rf_dump_streamer_if bus ();

    rf_dump_streamer #(.HEADER(8'hA5), .NREGS(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .pc_in    (pc_in),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .strm     (bus.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // sccomp register file model, combinational read
    logic [31:0] rf [32];
    always_comb reg_data = rf[reg_sel];

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q [$];
    logic [7:0] byte_q [$];
    bit         last_q [$];
    int         bcyc_q [$];
    int         done_cyc;
    int         busy_first, busy_last, busy_cnt;
    int         stab_err, stall_cnt;
    int         sel_hits [32];

    function automatic void build_exp(input logic [31:0] pc);
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(pc >> (24 - 8 * b)));
        for (int k = 0; k < 32; k++) begin
            w = (k == 0) ? 32'h0 : rf[k];
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (24 - 8 * b)));
        end
    endfunction

    // Runs one frame; start must already be driven for the accepting edge (cycle 0).
    task automatic capture(input bit bp, input bit spam);
        bit         prev_stall = 1'b0;
        logic [7:0] pb = '0;
        logic       pl = 1'b0;
        byte_q.delete(); last_q.delete(); bcyc_q.delete();
        done_cyc = -1; busy_first = 0; busy_last = 0; busy_cnt = 0;
        stab_err = 0; stall_cnt = 0;
        for (int k = 0; k < 32; k++) sel_hits[k] = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (prev_stall && !(bus.out_valid === 1'b1 && bus.out_byte === pb && bus.out_last === pl))
                stab_err++;
            if (busy) begin
                if (busy_first == 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
                if (!bus.out_valid) sel_hits[reg_sel]++;
            end
            if (done) begin
                done_cyc = c;
                return;
            end
            if (spam) pc_in = $urandom;
            else      start = 1'b0;
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                byte_q.push_back(bus.out_byte);
                last_q.push_back(bus.out_last);
                bcyc_q.push_back(c);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            if (prev_stall) stall_cnt++;
            pb = bus.out_byte;
            pl = bus.out_last;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; pc_in = '0; bus.out_ready = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_byte !== 8'h00) begin n_miss++; $display("FAIL rst_byte got %h want 00", bus.out_byte); end
        n_vec++; if (bus.out_last !== 1'b0) begin n_miss++; $display("FAIL rst_last got %b want 0", bus.out_last); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL rst_done got %b want 0", done); end
        n_vec++; if (reg_sel !== 5'd0) begin n_miss++; $display("FAIL rst_sel got %0d want 0", reg_sel); end
        rstn = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_full_dump;
        for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;
        @(negedge clk);
        pc_in = 32'h00000048; start = 1'b1;
        build_exp(pc_in);
        capture(1'b0, 1'b0);
        n_vec++; if (byte_q.size() != FRAME) begin n_miss++; $display("FAIL full_len got %0d want %0d", byte_q.size(), FRAME); end
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i] || last_q[i] !== (i == FRAME - 1)) begin
                n_miss++;
                $display("FAIL full_byte[%0d] got %h/last %b want %h/last %b", i,
                         (i < byte_q.size()) ? byte_q[i] : 8'hxx, (i < byte_q.size()) ? last_q[i] : 1'bx,
                         exp_q[i], (i == FRAME - 1));
            end
        end
        n_vec++; if (bcyc_q.size() == 0 || bcyc_q[0] != 1) begin n_miss++; $display("FAIL full_hdr_cycle want 1"); end
        n_vec++; if (done_cyc != 166) begin n_miss++; $display("FAIL full_done_cycle got %0d want 166", done_cyc); end
        n_vec++; if (busy_first != 1 || busy_last != 165 || busy_cnt != 165) begin
            n_miss++; $display("FAIL full_busy got %0d..%0d (%0d) want 1..165 (165)", busy_first, busy_last, busy_cnt);
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;
        @(negedge clk);
        pc_in = 32'h00000048; start = 1'b1;
        build_exp(pc_in);
        capture(1'b1, 1'b0);
        n_vec++; if (byte_q.size() != FRAME) begin n_miss++; $display("FAIL bp_len got %0d want %0d", byte_q.size(), FRAME); end
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL bp_byte[%0d] got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_vec++; if (stab_err != 0) begin n_miss++; $display("FAIL bp_stable got %0d violations want 0", stab_err); end
        n_vec++; if (stall_cnt == 0) begin n_miss++; $display("FAIL bp_stalls got 0 want >0"); end
        n_vec++; if (done_cyc < 0) begin n_miss++; $display("FAIL bp_done got timeout want pulse"); end
        for (int k = 0; k < 32; k++) begin
            n_vec++; if (sel_hits[k] != 1) begin n_miss++; $display("FAIL bp_sel[%0d] got %0d cycles want 1", k, sel_hits[k]); end
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_r0_forcing;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        rf[0] = 32'hDEADBEEF;
        @(negedge clk);
        pc_in = $urandom; start = 1'b1;
        build_exp(pc_in);
        capture(1'b0, 1'b0);
        for (int i = 5; i < 9; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== 8'h00) begin
                n_miss++; $display("FAIL r0_byte[%0d] got %h want 00", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) begin
                n_miss++; $display("FAIL r0_frame[%0d] got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp_q[i]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_start_spam;
        int extra_busy = 0;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        @(negedge clk);
        pc_in = $urandom; start = 1'b1;
        build_exp(pc_in);
        capture(1'b0, 1'b1);
        start = 1'b0;
        n_vec++; if (byte_q.size() != FRAME) begin n_miss++; $display("FAIL spam_len got %0d want %0d", byte_q.size(), FRAME); end
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) begin
                n_miss++; $display("FAIL spam_byte[%0d] got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp_q[i]);
            end
        end
        repeat (20) begin
            @(negedge clk);
            if (busy || bus.out_valid) extra_busy++;
        end
        n_vec++; if (extra_busy != 0) begin n_miss++; $display("FAIL spam_refire got %0d busy cycles want 0", extra_busy); end
    endtask

    task automatic test_reset_midframe;
        int cnt = 0;
        bit hit = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        @(negedge clk);
        pc_in = $urandom; start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
                if (cnt == 54) begin hit = 1'b1; break; end
                cnt++;
            end
        end
        n_vec++; if (!hit || reg_sel !== 5'd12) begin n_miss++; $display("FAIL mid_reach got sel %0d hit %b want sel 12 hit 1", reg_sel, hit); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_busy got %b want 0", busy); end
        n_vec++; if (reg_sel !== 5'd0) begin n_miss++; $display("FAIL mid_sel got %0d want 0", reg_sel); end
        n_vec++; if (bus.out_last !== 1'b0 || bus.out_byte !== 8'h00) begin
            n_miss++; $display("FAIL mid_byte got %h/%b want 00/0", bus.out_byte, bus.out_last);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        pc_in = $urandom; start = 1'b1;
        build_exp(pc_in);
        capture(1'b0, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) begin
                n_miss++; $display("FAIL mid_refresh[%0d] got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_vec++; if (done_cyc != 166) begin n_miss++; $display("FAIL mid_done got %0d want 166", done_cyc); end
        start = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc2;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        @(negedge clk);
        pc_in = $urandom; start = 1'b1;
        capture(1'b0, 1'b0);
        n_vec++; if (done_cyc != 166) begin n_miss++; $display("FAIL b2b_done1 got %0d want 166", done_cyc); end
        // start during the FIN cycle, carrying a PC that must never be latched
        start = 1'b1; pc_in = 32'hBAD0BAD0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_miss++; $display("FAIL b2b_fin_ignore got busy %b valid %b want 0 0", busy, bus.out_valid);
        end
        pc2 = $urandom; pc_in = pc2;
        build_exp(pc2);
        capture(1'b0, 1'b0);
        n_vec++; if (bcyc_q.size() == 0 || bcyc_q[0] != 1 || byte_q[0] !== 8'hA5) begin
            n_miss++; $display("FAIL b2b_hdr got cycle %0d want cycle 1 with A5", (bcyc_q.size() > 0) ? bcyc_q[0] : -1);
        end
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (i >= byte_q.size() || byte_q[i] !== exp_q[i]) begin
                n_miss++; $display("FAIL b2b_byte[%0d] got %h want %h", i, (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp_q[i]);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset;
        test_full_dump;
        test_backpressure;
        test_r0_forcing;
        test_start_spam;
        test_reset_midframe;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
